pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch/decode/execute controller that sequences the program-counter unit: generates its update, jump, offset and overflow controls.
- Handshakes with instruction memory (fetch) and the execute datapath.
- Sits between the instruction memory, the ALU/datapath and the PC unit, on the same clock as the PC unit.
- Provides halt, stall and fetch-timeout fault handling.

Parameters:
- OP_JMP, 4'hC, opcode of an unconditional relative jump (offset = instr[11:0]).
- OP_BRZ, 4'hD, opcode of a relative branch taken when zero_flag=1 (offset = instr[11:0]).
- OP_HLT, 4'hF, opcode of halt.
- TIMEOUT, 8'd255, max cycles waiting for fetch_ack before fault.

Ports:
- Clk2  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; 0 stalls sequencer in IDLE before the next fetch.
- fetch_req  out  1  instruction fetch request; held until fetch_ack.
- fetch_ack  in  1  one-cycle pulse; fetch_instr valid this cycle.
- fetch_instr  in  16  instruction word.
- ir  out  16  latched instruction register.
- exec_start  out  1  one-cycle pulse starting the datapath op.
- exec_done  in  1  one-cycle pulse, datapath op complete.
- exec_ovf  in  1  sampled with exec_done; arithmetic overflow.
- zero_flag  in  1  sampled in DECODE for OP_BRZ.
- updatePC  out  1  one-cycle pulse to PC unit.
- jump  out  1  valid with updatePC; select PC+offset.
- offset  out  12  relative offset to PC unit (ir[11:0]).
- overflow  out  1  one-cycle pulse to PC unit (forces PC to 16'hFFF0).
- halted  out  1  level, high in HALT.
- fault  out  1  level, high in FAULT.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ir=0; timer=0; every output 0. Deassertion is sampled on Clk2; reset mid-fetch drops fetch_req in the same instant.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, OVF, HALT, FAULT. All outputs are registered.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - fetch_req=1; timer increments each cycle.
  - On fetch_ack: ir<=fetch_instr, timer<=0, fetch_req drops next cycle, go to DECODE.
  - If timer reaches TIMEOUT with no ack: go to FAULT.
  - An ack on the same cycle the timer reaches TIMEOUT wins: go to DECODE.
- DECODE (opcode = ir[15:12]):
  - OP_HLT: go to HALT.
  - OP_JMP: jump_q=1, go to UPDATE.
  - OP_BRZ: jump_q=zero_flag, go to UPDATE.
  - Other opcodes: exec_start pulses in the cycle entering EXEC; jump_q=0.
- EXEC: wait for exec_done, with no timeout.
  - exec_done=1 and exec_ovf=1: go to OVF.
  - exec_done=1 and exec_ovf=0: go to UPDATE.
  - exec_done arriving in the same cycle as exec_start (zero-latency datapath) is legal.
- UPDATE: updatePC=1 for exactly one cycle, jump=jump_q, offset=ir[11:0] held stable; then IDLE if run=0, else FETCH.
- OVF: overflow=1 for exactly one cycle with updatePC=0; then to IDLE/FETCH as in UPDATE. The PC unit gives overflow priority over updatePC.
- HALT: halted=1; exit only via reset.
- FAULT: fault=1, fetch_req=0; exit only via reset.
- updatePC and overflow are never high together. exec_start is never high outside the DECODE→EXEC transition.
- run=0 is sampled only in IDLE and at UPDATE/OVF exit; an in-flight instruction always completes.
- offset holds ir[11:0] in all states. Sign extension is done by the PC unit.
- Minimum instruction latency: jump/branch takes 4 cycles (IDLE→FETCH with 1-cycle ack, DECODE, UPDATE). An ALU op takes 5 + datapath latency.

Decomposition:
- Shared package holds: opcode constants (OP_JMP/OP_BRZ/OP_HLT), the state encoding enum (3 bits), the 16'hFFF0 overflow vector, and the instruction field positions (opcode [15:12], offset [11:0]).
- One natural sub-module: fetch_timer (8-bit counter with clear/enable and TIMEOUT compare, outputs expired).

Test Plan:
- Reset then run=1, memory acks fetch 1 cycle after req with 16'hC005 → exactly one updatePC pulse with jump=1, offset=12'h005; no exec_start.
- 16'hD3FF with zero_flag=0 → updatePC with jump=0. Repeat with zero_flag=1 → jump=1, offset=12'h3FF.
- ALU opcode 16'h1234, exec_done 3 cycles after exec_start with exec_ovf=1 → one overflow pulse, no updatePC, then the next fetch_req.
- No fetch_ack for 255 cycles → fault=1, fetch_req=0 persisting. Repeat with ack at cycle 255 → DECODE, no fault.
- 16'hF000 → halted=1, no further fetch_req for 50 cycles even with run=1. Then reset_n=0 → all outputs 0 asynchronously.
- run dropped during EXEC → instruction completes with an updatePC pulse, then stays IDLE with fetch_req=0 until run=1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared constants, state encoding and instruction field helpers for the PC sequencer.
package pc_sequencer_pkg;

    localparam int INSTR_W = 16;
    localparam int OFF_W   = 12;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OFF_MSB = 11;
    localparam int OFF_LSB = 0;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BRZ = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [7:0]  TIMEOUT    = 8'd255;
    localparam logic [15:0] OVF_VECTOR = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_OVF,
        S_HALT,
        S_FAULT
    } state_t;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OFF_W-1:0] get_offset(input logic [INSTR_W-1:0] instr);
        return instr[OFF_MSB:OFF_LSB];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch, execute and PC-unit handshake signals around the sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic               run;
    logic               fetch_req;
    logic               fetch_ack;
    logic [INSTR_W-1:0] fetch_instr;
    logic [INSTR_W-1:0] ir;
    logic               exec_start;
    logic               exec_done;
    logic               exec_ovf;
    logic               zero_flag;
    logic               updatePC;
    logic               jump;
    logic [OFF_W-1:0]   offset;
    logic               overflow;
    logic               halted;
    logic               fault;

    modport master (
        input  run, fetch_ack, fetch_instr, exec_done, exec_ovf, zero_flag,
        output fetch_req, ir, exec_start, updatePC, jump, offset, overflow, halted, fault
    );

    modport slave (
        output run, fetch_ack, fetch_instr, exec_done, exec_ovf, zero_flag,
        input  fetch_req, ir, exec_start, updatePC, jump, offset, overflow, halted, fault
    );

endinterface

// File: rtl/pc_sequencer_fetch_timer.sv
// Counts cycles spent waiting for a fetch acknowledge and flags when the limit is hit.
module fetch_timer
    import pc_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;
    logic       w_expired;

    assign w_expired = (r_count == TIMEOUT);
    assign o_expired = w_expired;

    // Saturates at the limit so a stuck fetch never wraps back to a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller driving the PC unit's update, jump, offset and overflow controls.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic           Clk2,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_fetch_req;
    logic               r_exec_start;
    logic               r_update_pc;
    logic               r_jump;
    logic               r_overflow;
    logic               r_halted;
    logic               r_fault;

    logic               w_in_fetch;
    logic               w_timer_clear;
    logic               w_expired;

    assign w_in_fetch    = (r_state == S_FETCH);
    assign w_timer_clear = !w_in_fetch || bus.fetch_ack;

    fetch_timer u_fetch_timer (
        .clk       (Clk2),
        .rst_n     (reset_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_in_fetch),
        .o_expired (w_expired)
    );

    // Pulse outputs default low each cycle; only the transition that owns them raises them.
    always_ff @(posedge Clk2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_fetch_req  <= 1'b0;
            r_exec_start <= 1'b0;
            r_update_pc  <= 1'b0;
            r_jump       <= 1'b0;
            r_overflow   <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_exec_start <= 1'b0;
            r_update_pc  <= 1'b0;
            r_jump       <= 1'b0;
            r_overflow   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_fetch_req <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end

                // An acknowledge in the same cycle the timer expires still wins.
                S_FETCH: begin
                    if (bus.fetch_ack) begin
                        r_ir        <= bus.fetch_instr;
                        r_fetch_req <= 1'b0;
                        r_state     <= S_DECODE;
                    end else if (w_expired) begin
                        r_fetch_req <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= S_FAULT;
                    end
                end

                S_DECODE: begin
                    case (get_opcode(r_ir))
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        OP_JMP: begin
                            r_update_pc <= 1'b1;
                            r_jump      <= 1'b1;
                            r_state     <= S_UPDATE;
                        end
                        OP_BRZ: begin
                            r_update_pc <= 1'b1;
                            r_jump      <= bus.zero_flag;
                            r_state     <= S_UPDATE;
                        end
                        default: begin
                            r_exec_start <= 1'b1;
                            r_state      <= S_EXEC;
                        end
                    endcase
                end

                S_EXEC: begin
                    if (bus.exec_done) begin
                        if (bus.exec_ovf) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_OVF;
                        end else begin
                            r_update_pc <= 1'b1;
                            r_state     <= S_UPDATE;
                        end
                    end
                end

                S_UPDATE, S_OVF: begin
                    if (bus.run) begin
                        r_fetch_req <= 1'b1;
                        r_state     <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_HALT: begin
                    r_halted <= 1'b1;
                end

                S_FAULT: begin
                    r_fault     <= 1'b1;
                    r_fetch_req <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_req  = r_fetch_req;
    assign bus.ir         = r_ir;
    assign bus.exec_start = r_exec_start;
    assign bus.updatePC   = r_update_pc;
    assign bus.jump       = r_jump;
    assign bus.offset     = get_offset(r_ir);
    assign bus.overflow   = r_overflow;
    assign bus.halted     = r_halted;
    assign bus.fault      = r_fault;

endmodule
